// File: rtl/mac_accum_4b.sv
// Pipelined 4x4 unsigned multiply-accumulate over in_last-delimited frames.
// The stages are: operand register, product register, then a saturating accumulator with a RUN/HOLD FSM.

module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    assign o = x * y;
endmodule

module mac_accum_4b #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_count,
    output logic             out_ovf
);
    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    state_t           state;
    logic             last_in_flight;
    logic             accept;
    logic             s1_valid;
    logic             s1_last;
    logic [3:0]       s1_a;
    logic [3:0]       s1_b;
    logic [7:0]       prod;
    logic             p_valid;
    logic             p_last;
    logic [7:0]       p_prod;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] count;
    logic             ovf;
    logic [ACC_W:0]   acc_sum;

    // Only one frame may be in flight: the next frame's beats wait until the result is taken.
    assign in_ready = ~last_in_flight & ~rst;
    assign accept   = in_valid & in_ready;
    assign acc_sum  = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, p_prod};

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            p_valid  <= 1'b0;
        end else begin
            s1_valid <= accept;
            p_valid  <= s1_valid;
        end
    end

    // NOTE: pure datapath registers carry no reset; the valid flags qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_last <= in_last;
        end
        p_prod <= prod;
        p_last <= s1_last;
    end

    main u_mul (
        .x (s1_a),
        .y (s1_b),
        .o (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            acc            <= '0;
            count          <= '0;
            ovf            <= 1'b0;
            last_in_flight <= 1'b0;
            out_valid      <= 1'b0;
            out_sum        <= '0;
            out_count      <= '0;
            out_ovf        <= 1'b0;
        end else begin
            if (accept && in_last)
                last_in_flight <= 1'b1;
            case (state)
                RUN: begin
                    if (p_valid) begin
                        if (acc_sum[ACC_W]) begin
                            acc <= ACC_MAX;
                            ovf <= 1'b1;
                        end else begin
                            acc <= acc_sum[ACC_W-1:0];
                        end
                        if (count != LEN_MAX)
                            count <= count + LEN_ONE;
                        if (p_last)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    // First HOLD cycle snapshots the frame into the output registers.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_sum   <= acc;
                        out_count <= count;
                        out_ovf   <= ovf;
                    end else if (out_ready) begin
                        out_valid      <= 1'b0;
                        acc            <= '0;
                        count          <= '0;
                        ovf            <= 1'b0;
                        last_in_flight <= 1'b0;
                        state          <= RUN;
                    end
                end
            endcase
        end
    end
endmodule
